cas_ram_arbiter: RTL and testbench

- Arbitrates the single-port cassette buffer RAM (64 KB, synchronous read) between two requesters: the HPS ioctl tape-download writer and the cassette player's byte reads.
- Replaces the ad-hoc address mux in front of that RAM.
- Tracks the loaded tape length and flags reads past end-of-tape.
- Sits between hps_io/cassette and the RAM instance in the emu top.

---
 rtl/cas_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cas_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_ram_arbiter.sv
// cas_ram_arbiter: shares the single-port cassette buffer RAM between the HPS
// tape-download writer (ioctl) and the cassette player's byte reads.
// A one-entry write buffer absorbs ioctl strobes. Writes always win at IDLE.
// tape_len tracks the highest address written + 1. Reads at or past it return
// rd_eof without waiting for the RAM.
// Optional feature: define CAS_ARB_CHECKSUM_EN to get a running 8-bit byte sum
// of committed writes on 'checksum'. When it is undefined, checksum is tied to 0.
module cas_ram_arbiter #(
  parameter int AW       = 16,
  parameter int RD_LAT   = 1,
  parameter int TAPE_IDX = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic          rd_eof,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic [AW:0]   tape_len,
  output logic          busy,
  output logic          wr_overflow,
  output logic [7:0]    checksum
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_RDONE = 3'd4;

  // Last wait-count value before the RAM data is ready (RD_LAT is 1..3).
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  logic [2:0]    state;
  logic          tape_sel, tape_sel_q, tape_rise;
  logic          wr_cap, drain;
  logic          buf_full;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic [1:0]    lat_cnt;
  logic          eof_q;
  logic [AW:0]   wr_end;

  assign tape_sel  = ioctl_download & (ioctl_index == 8'(TAPE_IDX));
  assign tape_rise = tape_sel & ~tape_sel_q;
  assign wr_cap    = ioctl_wr & tape_sel;
  assign drain     = (state == S_WRITE);
  // Extend by one bit before adding 1, so a write to the top address gives 2^AW.
  assign wr_end    = {1'b0, ram_addr} + {{AW{1'b0}}, 1'b1};
  assign busy      = (state != S_IDLE) | buf_full;

  // Remember the previous tape_sel so that the start of a download can be detected.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) tape_sel_q <= 1'b0;
    else       tape_sel_q <= tape_sel;
  end

  // One-entry write buffer. A capture is accepted on the same edge the entry drains.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (wr_cap && (!buf_full || drain)) begin
      buf_full <= 1'b1;
      buf_addr <= ioctl_addr;
      buf_data <= ioctl_data;
    end else if (drain) begin
      buf_full <= 1'b0;
    end
  end

  // Sticky flag for a dropped write. A drop on the start edge still wins over the clear.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                wr_overflow <= 1'b0;
    else if (wr_cap && buf_full && !drain)    wr_overflow <= 1'b1;
    else if (tape_rise)                       wr_overflow <= 1'b0;
  end

  // Tape length: cleared when a new download starts, raised by each committed write.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                  tape_len <= '0;
    else if (tape_rise)                         tape_len <= '0;
    else if (state == S_WRITE && wr_end > tape_len) tape_len <= wr_end;
  end

`ifdef CAS_ARB_CHECKSUM_EN
  logic [7:0] sum_q;

  // Wrapping sum of committed bytes. It is visible on the cycle after WRITE.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                  sum_q <= 8'd0;
    else if (tape_rise)         sum_q <= 8'd0;
    else if (state == S_WRITE)  sum_q <= sum_q + ram_din;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'd0;
`endif

  // Arbitration FSM. It owns the RAM port and produces the read handshake pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= 8'd0;
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
      rd_eof   <= 1'b0;
      lat_cnt  <= 2'd0;
      eof_q    <= 1'b0;
    end else begin
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      ram_we   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (buf_full) begin
            state    <= S_WRITE;
            ram_we   <= 1'b1;
            ram_addr <= buf_addr;
            ram_din  <= buf_data;
          end else if (rd_req && !tape_sel) begin
            ram_addr <= rd_addr;
            rd_ack   <= 1'b1;
            lat_cnt  <= 2'd0;
            if ({1'b0, rd_addr} >= tape_len) begin
              eof_q <= 1'b1;
              state <= S_RDONE;
            end else begin
              eof_q <= 1'b0;
              state <= S_READ;
            end
          end
        end
        S_WRITE: state <= S_IDLE;
        S_READ: begin
          lat_cnt <= lat_cnt + 2'd1;
          state   <= (LAT_LAST == 2'd0) ? S_RDONE : S_RWAIT;
        end
        S_RWAIT: begin
          if (lat_cnt == LAT_LAST) state <= S_RDONE;
          else                     lat_cnt <= lat_cnt + 2'd1;
        end
        S_RDONE: begin
          rd_valid <= 1'b1;
          rd_data  <= eof_q ? 8'd0 : ram_dout;
          rd_eof   <= eof_q;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_ram_arbiter.sv
// Directed bench for cas_ram_arbiter. The main instance uses RD_LAT=1, and a
// second instance uses RD_LAT=3. Both share the stimulus and each has its own RAM model.
module tb_cas_ram_arbiter;

`ifdef CAS_ARB_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        rd_req;
  logic [15:0] rd_addr;

  logic        rd_ack, rd_valid, rd_eof, ram_we, busy, wr_overflow;
  logic [7:0]  rd_data, ram_din, ram_dout, checksum;
  logic [15:0] ram_addr;
  logic [16:0] tape_len;

  logic        b_rd_ack, b_rd_valid, b_rd_eof, b_ram_we, b_busy, b_wr_overflow;
  logic [7:0]  b_rd_data, b_ram_din, b_ram_dout, b_checksum;
  logic [15:0] b_ram_addr;
  logic [16:0] b_tape_len;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  logic [7:0] b_p0, b_p1;
  logic [7:0] dl_bytes [4];

  cas_ram_arbiter #(.AW(16), .RD_LAT(1), .TAPE_IDX(2)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_eof(rd_eof), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .tape_len(tape_len), .busy(busy),
    .wr_overflow(wr_overflow), .checksum(checksum)
  );

  cas_ram_arbiter #(.AW(16), .RD_LAT(3), .TAPE_IDX(2)) dut3 (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(b_rd_ack), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .rd_eof(b_rd_eof), .ram_addr(b_ram_addr), .ram_we(b_ram_we),
    .ram_din(b_ram_din), .ram_dout(b_ram_dout), .tape_len(b_tape_len), .busy(b_busy),
    .wr_overflow(b_wr_overflow), .checksum(b_checksum)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // RAM model with a synchronous read, latency 1.
  always @(posedge clk_sys) begin
    if (ram_we) mem_a[ram_addr] <= ram_din;
    ram_dout <= mem_a[ram_addr];
  end

  // RAM model with a synchronous read, latency 3.
  always @(posedge clk_sys) begin
    if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
    b_p0       <= mem_b[b_ram_addr];
    b_p1       <= b_p0;
    b_ram_dout <= b_p1;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    dl_bytes = '{8'hAA, 8'h55, 8'h01, 8'hFF};
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 16'd0; ioctl_data = 8'd0; rd_req = 1'b0; rd_addr = 16'd0;
    tick(); tick();

    // Reset state of both instances
    chk("rst_ack", 32'(rd_ack), 0);        chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);      chk("rst_eof", 32'(rd_eof), 0);
    chk("rst_raddr", 32'(ram_addr), 0);    chk("rst_we", 32'(ram_we), 0);
    chk("rst_din", 32'(ram_din), 0);       chk("rst_len", 32'(tape_len), 0);
    chk("rst_busy", 32'(busy), 0);         chk("rst_ovf", 32'(wr_overflow), 0);
    chk("rst_ck", 32'(checksum), 0);
    chk("b_rst_ack", 32'(b_rd_ack), 0);    chk("b_rst_valid", 32'(b_rd_valid), 0);
    chk("b_rst_data", 32'(b_rd_data), 0);  chk("b_rst_eof", 32'(b_rd_eof), 0);
    chk("b_rst_raddr", 32'(b_ram_addr), 0); chk("b_rst_we", 32'(b_ram_we), 0);
    chk("b_rst_din", 32'(b_ram_din), 0);   chk("b_rst_len", 32'(b_tape_len), 0);
    chk("b_rst_busy", 32'(b_busy), 0);     chk("b_rst_ovf", 32'(b_wr_overflow), 0);
    chk("b_rst_ck", 32'(b_checksum), 0);
    reset = 1'b0;
    tick();

    // Download four bytes at addresses 0..3, one every 4 clocks
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 16'(i); ioctl_data = dl_bytes[i];
      tick();
      ioctl_wr = 1'b0;
      chk("dl_busy", 32'(busy), 1);
      chk("dl_we_pre", 32'(ram_we), 0);
      tick();
      chk("dl_we", 32'(ram_we), 1);
      chk("dl_addr", 32'(ram_addr), 32'(i));
      chk("dl_din", 32'(ram_din), 32'(dl_bytes[i]));
      tick();
      chk("dl_we_post", 32'(ram_we), 0);
      chk("dl_len", 32'(tape_len), 32'(i + 1));
      tick();
    end
    ioctl_download = 1'b0;
    tick();
    chk("dl_ovf", 32'(wr_overflow), 0);
    chk("dl_len_final", 32'(tape_len), 4);
    chk("dl_ck", 32'(checksum), CK_EN ? 32'hFF : 32'h0);
    chk("dl_idle", 32'(busy), 0);

    // In-range read of address 2
    rd_req = 1'b1; rd_addr = 16'd2;
    tick();
    chk("rd2_ack", 32'(rd_ack), 1);
    chk("rd2_raddr", 32'(ram_addr), 2);
    rd_req = 1'b0;
    tick();
    chk("rd2_ack_pulse", 32'(rd_ack), 0);
    chk("rd2_valid_early", 32'(rd_valid), 0);
    tick();
    chk("rd2_valid", 32'(rd_valid), 1);
    chk("rd2_data", 32'(rd_data), 32'h01);
    chk("rd2_eof", 32'(rd_eof), 0);
    tick();
    chk("rd2_valid_pulse", 32'(rd_valid), 0);

    // Read at end of tape: address 4 with tape_len 4
    rd_req = 1'b1; rd_addr = 16'd4;
    tick();
    chk("eof_ack", 32'(rd_ack), 1);
    chk("eof_we", 32'(ram_we), 0);
    rd_req = 1'b0;
    tick();
    chk("eof_valid", 32'(rd_valid), 1);
    chk("eof_data", 32'(rd_data), 0);
    chk("eof_flag", 32'(rd_eof), 1);
    tick();

    // Write that arrives during a read, with a second read pending
    rd_req = 1'b1; rd_addr = 16'd1;
    tick();
    chk("wr_rd1_ack", 32'(rd_ack), 1);
    rd_addr = 16'd3;
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    ioctl_wr = 1'b1; ioctl_addr = 16'd5; ioctl_data = 8'h3C;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    chk("wr_rd1_busy", 32'(busy), 1);
    tick();
    chk("wr_rd1_valid", 32'(rd_valid), 1);
    chk("wr_rd1_data", 32'(rd_data), 32'h55);
    tick();
    chk("wr_first_we", 32'(ram_we), 1);
    chk("wr_first_addr", 32'(ram_addr), 5);
    chk("wr_first_noack", 32'(rd_ack), 0);
    tick();
    chk("wr_len", 32'(tape_len), 6);
    chk("wr_noack2", 32'(rd_ack), 0);
    chk("wr_ck", 32'(checksum), CK_EN ? 32'h3C : 32'h0);
    tick();
    chk("rd2nd_ack", 32'(rd_ack), 1);
    rd_req = 1'b0;
    tick();
    tick();
    chk("rd2nd_valid", 32'(rd_valid), 1);
    chk("rd2nd_data", 32'(rd_data), 32'hFF);
    chk("rd2nd_eof", 32'(rd_eof), 0);
    tick();

    // rd_req stalls while tape_sel is high; a write to 0xFFFF gives tape_len 0x10000
    rd_req = 1'b1; rd_addr = 16'd0;
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    tick();
    chk("stall_ack0", 32'(rd_ack), 0);
    chk("stall_len_clr", 32'(tape_len), 0);
    tick();
    chk("stall_ack1", 32'(rd_ack), 0);
    ioctl_wr = 1'b1; ioctl_addr = 16'hFFFF; ioctl_data = 8'h77;
    tick();
    ioctl_wr = 1'b0;
    chk("stall_ack2", 32'(rd_ack), 0);
    tick();
    chk("top_we", 32'(ram_we), 1);
    chk("top_addr", 32'(ram_addr), 32'hFFFF);
    tick();
    chk("top_len", 32'(tape_len), 32'h10000);
    chk("stall_ack3", 32'(rd_ack), 0);
    tick();
    chk("stall_ack4", 32'(rd_ack), 0);
    ioctl_download = 1'b0;
    tick();
    chk("stall_release_ack", 32'(rd_ack), 1);
    rd_req = 1'b0;
    tick();
    tick();
    chk("stall_rd_valid", 32'(rd_valid), 1);
    chk("stall_rd_data", 32'(rd_data), 32'hAA);
    tick();

    // A write with a non-tape index is ignored
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    ioctl_wr = 1'b1; ioctl_addr = 16'd7; ioctl_data = 8'h11;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    chk("other_idx_busy", 32'(busy), 0);
    tick();
    chk("other_idx_we", 32'(ram_we), 0);

    // Reset asserted one cycle after rd_ack abandons the read
    rd_req = 1'b1; rd_addr = 16'h0100;
    tick();
    chk("mid_ack", 32'(rd_ack), 1);
    rd_req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rd_valid), 0);
    chk("mid_rst_ack", 32'(rd_ack), 0);
    chk("mid_rst_len", 32'(tape_len), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_raddr", 32'(ram_addr), 0);
    chk("mid_rst_data", 32'(rd_data), 0);
    tick();
    reset = 1'b0;
    chk("mid_rst_valid1", 32'(rd_valid), 0);
    tick();
    chk("mid_rst_valid2", 32'(rd_valid), 0);
    tick();
    chk("mid_rst_valid3", 32'(rd_valid), 0);

    // RD_LAT=3 instance: load a byte, then drop a back-to-back write during RWAIT
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    ioctl_wr = 1'b1; ioctl_addr = 16'd9; ioctl_data = 8'h5A;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    tick();
    tick();
    chk("b_len10", 32'(b_tape_len), 10);
    rd_req = 1'b1; rd_addr = 16'd9;
    tick();
    chk("b_ack", 32'(b_rd_ack), 1);
    rd_req = 1'b0;
    tick();
    chk("b_valid_k2", 32'(b_rd_valid), 0);
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    ioctl_wr = 1'b1; ioctl_addr = 16'd20; ioctl_data = 8'h01;
    tick();
    chk("b_valid_k3", 32'(b_rd_valid), 0);
    chk("b_ovf_first", 32'(b_wr_overflow), 0);
    ioctl_addr = 16'd21; ioctl_data = 8'h02;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    chk("b_ovf", 32'(b_wr_overflow), 1);
    chk("b_valid_k4", 32'(b_rd_valid), 0);
    tick();
    chk("b_valid", 32'(b_rd_valid), 1);
    chk("b_data", 32'(b_rd_data), 32'h5A);
    chk("b_eof", 32'(b_rd_eof), 0);
    tick();
    chk("b_wr_we", 32'(b_ram_we), 1);
    chk("b_wr_addr", 32'(b_ram_addr), 20);
    tick();
    chk("b_len21", 32'(b_tape_len), 21);
    chk("b_ovf_sticky", 32'(b_wr_overflow), 1);
    chk("b_ck", 32'(b_checksum), CK_EN ? 32'h01 : 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
